std_mem_d1_loader: RTL and testbench

//   Write-side initiator for a 1-D memory with the write_en/done protocol
//   (addr0, write_data, write_en in; done out one cycle after an accepted write).

---
 rtl/std_mem_d1_loader_if.sv | 28 ++
 rtl/std_mem_d1_loader.sv | 127 ++++++++++++
 tb/tb_std_mem_d1_loader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_mem_d1_loader_if.sv
// Bundle between the loader and its environment: start/length control,
// the incoming valid/ready word stream and the write_en/done memory port.
interface std_mem_d1_loader_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4
);
    logic                go;
    logic [IDX_SIZE:0]   len;
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic [WIDTH-1:0]    mem_write_data;
    logic                mem_write_en;
    logic                mem_done;
    logic [IDX_SIZE:0]   count;
    logic                done;

    modport master (
        output go, len, in_data, in_valid, mem_done,
        input  in_ready, mem_addr0, mem_write_data, mem_write_en, count, done
    );

    modport slave (
        input  go, len, in_data, in_valid, mem_done,
        output in_ready, mem_addr0, mem_write_data, mem_write_en, count, done
    );
endinterface

// File: rtl/std_mem_d1_loader.sv
// Fills a 1-D memory from address 0 upward with words drained from a
// valid/ready stream, one write_en/done transaction per word.
module std_mem_d1_loader #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input logic                clk,
    input logic                reset,
    std_mem_d1_loader_if.slave bus
);
    localparam logic [IDX_SIZE:0]   SIZE_L   = SIZE[IDX_SIZE:0];
    localparam logic [IDX_SIZE:0]   CNT_ONE  = {{IDX_SIZE{1'b0}}, 1'b1};
    localparam logic [IDX_SIZE-1:0] ADDR_ONE = {{(IDX_SIZE-1){1'b0}}, 1'b1};

    if ((1 << IDX_SIZE) < SIZE) begin : g_size_check
        $error("std_mem_d1_loader: 2**IDX_SIZE must be >= SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t              state, state_next;
    logic [IDX_SIZE:0]   len_clamp;
    logic [IDX_SIZE:0]   len_q;
    logic [IDX_SIZE:0]   count_q;
    logic [IDX_SIZE:0]   count_inc;
    logic [IDX_SIZE-1:0] addr_q;
    logic [WIDTH-1:0]    data_q;
    logic                in_ready_c;
    logic                write_en_c;
    logic                done_c;

    assign len_clamp = (bus.len > SIZE_L) ? SIZE_L : bus.len;
    assign count_inc = count_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (bus.go) begin
                    state_next = (len_clamp == '0) ? S_FIN : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (bus.in_valid) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.mem_done) begin
                    state_next = (count_inc == len_q) ? S_FIN : S_ACCEPT;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        write_en_c = 1'b0;
        done_c     = 1'b0;
        unique case (state)
            S_ACCEPT: in_ready_c = 1'b1;
            S_WRITE:  write_en_c = 1'b1;
            S_FIN:    done_c     = 1'b1;
            default:  ;
        endcase
    end

    // Run bookkeeping: length latch, word counter, address and write data.
    // The address only advances when more words remain, so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        len_q   <= len_clamp;
                        count_q <= '0;
                        addr_q  <= '0;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        data_q <= bus.in_data;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_done) begin
                        count_q <= count_inc;
                        if (count_inc != len_q) begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.mem_write_en   = write_en_c;
    assign bus.done           = done_c;
    assign bus.mem_addr0      = addr_q;
    assign bus.mem_write_data = data_q;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_std_mem_d1_loader.sv
// Directed bench for std_mem_d1_loader with a behavioural memory that
// acknowledges each write after a programmable number of cycles.
module tb_std_mem_d1_loader;
    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int IDX_SIZE = 4;

    logic clk = 1'b0;
    logic reset;

    std_mem_d1_loader_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

    std_mem_d1_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_dly = 1;
    int wen_cycles = 0;
    int rdy_cycles = 0;
    int done_pulses = 0;
    int hold_err = 0;
    int rdy_drop = 0;
    int done_cyc = 0;
    int mdone_cyc = 0;
    logic [IDX_SIZE-1:0] wr_addr[$];
    logic [WIDTH-1:0]    wr_data[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.mem_write_en === 1'b1) wen_cycles++;
        if (bus.in_ready === 1'b1) rdy_cycles++;
        if (bus.done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
    end

    // Memory model: logs each write, checks the port holds still while the
    // acknowledge is pending, then returns mem_done for one cycle.
    initial begin
        logic [IDX_SIZE-1:0] a;
        logic [WIDTH-1:0]    d;
        bus.mem_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_write_en === 1'b1) begin
                a = bus.mem_addr0;
                d = bus.mem_write_data;
                wr_addr.push_back(a);
                wr_data.push_back(d);
                for (int i = 0; i < mem_dly; i++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) break;
                    if (bus.mem_addr0 !== a || bus.mem_write_data !== d ||
                        bus.in_ready !== 1'b0 || bus.mem_write_en !== 1'b0) hold_err++;
                end
                if (reset === 1'b1) begin
                    bus.mem_done = 1'b1;
                    mdone_cyc = cyc;
                    @(negedge clk);
                    bus.mem_done = 1'b0;
                end
            end
        end
    end

    task automatic clear_stats();
        wr_addr.delete();
        wr_data.delete();
        wen_cycles  = 0;
        rdy_cycles  = 0;
        done_pulses = 0;
        hold_err    = 0;
        rdy_drop    = 0;
    endtask

    task automatic start_run(input int l);
        @(negedge clk);
        bus.len = l[IDX_SIZE:0];
        bus.go  = 1'b1;
        @(negedge clk);
        bus.go  = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input int gap, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready === 1'b1) begin
            for (int g = 0; g < gap; g++) begin
                if (bus.in_ready !== 1'b1) rdy_drop++;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            @(negedge clk);
            bus.in_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int t = 0;
        while (bus.done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.done === 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.go = 1'b0;
        bus.len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", bus.mem_write_en); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.mem_addr0 !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.mem_addr0); end
        checks++; if (bus.mem_write_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.mem_write_data); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        logic [WIDTH-1:0] exp_d[3] = '{32'hA, 32'hB, 32'hC};
        clear_stats();
        mem_dly = 1;
        start_run(3);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_go_latency: in_ready=%b expected 1", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            push(exp_d[i], 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL basic_push%0d: no in_ready got 0 expected 1", i); end
        end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got 0 expected 1"); end
        checks++; if (wr_addr.size() != 3) begin errors++; $display("FAIL basic_nwrites: got %0d expected 3", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
            checks++;
            if (wr_addr[i] !== i[IDX_SIZE-1:0] || wr_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got (%0h,%0h) expected (%0h,%0h)", i, wr_addr[i], wr_data[i], i, exp_d[i]);
            end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (done_cyc - mdone_cyc != 1) begin errors++; $display("FAIL basic_done_latency: got %0d expected 1", done_cyc - mdone_cyc); end
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", bus.count); end
        checks++; if (wen_cycles != 3) begin errors++; $display("FAIL basic_wen_cycles: got %0d expected 3", wen_cycles); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL basic_hold: got %0d expected 0", hold_err); end
    endtask

    task automatic test_zero_len();
        clear_stats();
        start_run(0);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done_timing: got %b expected 1", bus.done); end
        repeat (3) @(negedge clk);
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (rdy_cycles != 0) begin errors++; $display("FAIL zero_in_ready: got %0d expected 0", rdy_cycles); end
        checks++; if (wen_cycles != 0) begin errors++; $display("FAIL zero_write_en: got %0d expected 0", wen_cycles); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_valid_gaps();
        bit ok;
        logic [WIDTH-1:0] exp_d[2] = '{32'h1234_5678, 32'hDEAD_BEEF};
        clear_stats();
        mem_dly = 1;
        start_run(2);
        for (int i = 0; i < 2; i++) begin
            push(exp_d[i], 5, ok);
            checks++; if (!ok) begin errors++; $display("FAIL gap_push%0d: no in_ready got 0 expected 1", i); end
        end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_done_timeout: got 0 expected 1"); end
        checks++; if (rdy_drop != 0) begin errors++; $display("FAIL gap_ready_drop: got %0d expected 0", rdy_drop); end
        checks++; if (wen_cycles != 2) begin errors++; $display("FAIL gap_wen_cycles: got %0d expected 2", wen_cycles); end
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL gap_nwrites: got %0d expected 2", wr_data.size()); end
        for (int i = 0; i < wr_data.size() && i < 2; i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL gap_data%0d: got %0h expected %0h", i, wr_data[i], exp_d[i]); end
        end
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL gap_count: got %0d expected 2", bus.count); end
    endtask

    task automatic test_slow_mem();
        bit ok;
        clear_stats();
        mem_dly = 4;
        start_run(2);
        push(32'h0F0F_0F0F, 0, ok);
        push(32'hF0F0_F0F0, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_push: no in_ready got 0 expected 1"); end
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_done_timeout: got 0 expected 1"); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL slow_hold: got %0d expected 0", hold_err); end
        checks++; if (wen_cycles != 2) begin errors++; $display("FAIL slow_wen_cycles: got %0d expected 2", wen_cycles); end
        checks++; if (wr_addr.size() != 2 || wr_addr[wr_addr.size()-1] !== 4'd1) begin
            errors++; $display("FAIL slow_last_addr: got %0d writes expected 2 ending at addr 1", wr_addr.size());
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL slow_done_pulses: got %0d expected 1", done_pulses); end
        mem_dly = 1;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        clear_stats();
        mem_dly = 6;
        start_run(4);
        push(32'h111, 0, ok);
        push(32'h222, 0, ok);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.mem_write_en !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got rdy=%b wen=%b done=%b expected all 0", bus.in_ready, bus.mem_write_en, bus.done);
        end
        checks++; if (bus.mem_addr0 !== '0 || bus.mem_write_data !== '0 || bus.count !== '0) begin
            errors++; $display("FAIL midrst_data: got addr=%0h data=%0h count=%0d expected all 0", bus.mem_addr0, bus.mem_write_data, bus.count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (done_pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_pulses); end
        clear_stats();
        mem_dly = 1;
        start_run(1);
        push(32'h55, 0, ok);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_done_timeout: got 0 expected 1"); end
        checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h55) begin
            errors++; $display("FAIL midrst_rerun_write: got %0d writes first (%0h,%0h) expected 1 write (0,55)", wr_addr.size(), wr_addr[0], wr_data[0]);
        end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", bus.count); end
    endtask

    task automatic test_len_clamp();
        bit ok;
        int bad = 0;
        clear_stats();
        mem_dly = 1;
        start_run(20);
        for (int i = 0; i < SIZE; i++) begin
            push(WIDTH'(i * 3 + 1), 0, ok);
            if (!ok) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clamp_push: got %0d stalls expected 0", bad); end
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout: got 0 expected 1"); end
        checks++; if (wr_addr.size() != SIZE) begin errors++; $display("FAIL clamp_nwrites: got %0d expected %0d", wr_addr.size(), SIZE); end
        for (int i = 0; i < wr_addr.size() && i < SIZE; i++) begin
            checks++;
            if (wr_addr[i] !== i[IDX_SIZE-1:0] || wr_data[i] !== WIDTH'(i * 3 + 1)) begin
                errors++; $display("FAIL clamp_write%0d: got (%0h,%0h) expected (%0h,%0h)", i, wr_addr[i], wr_data[i], i, i * 3 + 1);
            end
        end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL clamp_count: got %0d expected 16", bus.count); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL clamp_done_pulses: got %0d expected 1", done_pulses); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clamp_idle_ready: got %b expected 0", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_stats();
        mem_dly = 1;
        @(negedge clk);
        bus.len = 5'd1;
        bus.go  = 1'b1;
        push(32'h77, 0, ok);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done: got 0 expected 1"); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_restart: in_ready got %b expected 1", bus.in_ready); end
        bus.go = 1'b0;
        push(32'h88, 0, ok);
        wait_done(30, ok);
        checks++; if (wr_addr.size() != 2 || wr_addr[1] !== 4'd0 || wr_data[1] !== 32'h88) begin
            errors++; $display("FAIL b2b_second_write: got %0d writes expected 2 with (0,88) last", wr_addr.size());
        end
        checks++; if (done_pulses != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_valid_gaps();
        test_slow_mem();
        test_reset_mid_run();
        test_len_clamp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete expected finish");
        $fatal(1);
    end
endmodule
